// File: rtl/i2c_master_ctrl.sv
// rtl/i2c_master_ctrl.sv - I2C master control: SCL divider, transaction FSM, host handshake
// State codes are consumed directly by the downstream SDA datapath.
module i2c_master_ctrl #(
  parameter int CLK_DIV  = 4,
  parameter int ADDR_BIT = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rd_wr_in,
  input  logic       more,
  input  logic       sda_in,
  output logic       scl_clk,
  output logic [2:0] state,
  output logic       rd_wr_en,
  output logic       busy,
  output logic       byte_done,
  output logic       ack_err,
  output logic       done
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = ($clog2(ADDR_BIT + 1) > 3) ? $clog2(ADDR_BIT + 1) : 3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    ADDR      = 3'd2,
    ACK_ADDR  = 3'd3,
    WR_RD     = 3'd4,
    ACK_WR_RD = 3'd5,
    STOP      = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_cnt, bit_cnt_d;
  logic          tick;
  logic          req;
  logic          take_req, set_err, byte_done_d, done_d;

  // One clk after each SCL rise, so state holds across the next fall and rise.
  assign tick  = scl_clk && (cnt == '0);
  assign state = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      scl_clk <= 1'b1;
    end else if (cnt == CW'(CLK_DIV - 1)) begin
      cnt     <= '0;
      scl_clk <= ~scl_clk;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      bit_cnt <= '0;
    end else begin
      state_q <= state_d;
      bit_cnt <= bit_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req       <= 1'b0;
      busy      <= 1'b0;
      rd_wr_en  <= 1'b0;
      ack_err   <= 1'b0;
      byte_done <= 1'b0;
      done      <= 1'b0;
    end else begin
      byte_done <= byte_done_d;
      done      <= done_d;
      if (start && !busy) begin
        req      <= 1'b1;
        busy     <= 1'b1;
        rd_wr_en <= rd_wr_in;
        ack_err  <= 1'b0;
      end else begin
        if (take_req) req     <= 1'b0;
        if (set_err)  ack_err <= 1'b1;
        if (done_d)   busy    <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt;
    take_req    = 1'b0;
    set_err     = 1'b0;
    byte_done_d = 1'b0;
    done_d      = 1'b0;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (req) begin
            state_d  = START;
            take_req = 1'b1;
          end
        end
        START: begin
          state_d   = ADDR;
          bit_cnt_d = BW'(ADDR_BIT);
        end
        ADDR: begin
          if (bit_cnt != '0) bit_cnt_d = bit_cnt - BW'(1);
          else               state_d   = ACK_ADDR;
        end
        ACK_ADDR: begin
          if (sda_in) begin
            set_err = 1'b1;
            state_d = STOP;
          end else begin
            state_d   = WR_RD;
            bit_cnt_d = BW'(7);
          end
        end
        WR_RD: begin
          if (bit_cnt != '0) begin
            bit_cnt_d = bit_cnt - BW'(1);
          end else begin
            state_d     = ACK_WR_RD;
            byte_done_d = 1'b1;
          end
        end
        ACK_WR_RD: begin
          // On reads the master drives the ACK, so SDA is not checked.
          if (!rd_wr_en && sda_in) begin
            set_err = 1'b1;
            state_d = STOP;
          end else if (more) begin
            state_d   = WR_RD;
            bit_cnt_d = BW'(7);
          end else begin
            state_d = STOP;
          end
        end
        STOP: begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
